// File: rtl/rename_map.sv
// Register alias table for the rename stage: maps architectural to physical
// registers, allocates destinations from the free list and keeps branch checkpoints.
module rename_map #(
  parameter int AWIDTH = 5,
  parameter int PWIDTH = 6,
  parameter int CKNUM  = 4,
  localparam int CKW   = (CKNUM > 1) ? $clog2(CKNUM) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_rs1,
  input  logic [AWIDTH-1:0] i_rs2,
  input  logic [AWIDTH-1:0] i_rd,
  input  logic              i_rd_we,
  input  logic              i_chk_save,
  input  logic [PWIDTH-1:0] i_fl_data,
  input  logic              i_fl_empty,
  output logic              o_fl_re,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PWIDTH-1:0] o_prs1,
  output logic [PWIDTH-1:0] o_prs2,
  output logic [PWIDTH-1:0] o_prd,
  output logic [PWIDTH-1:0] o_pold,
  output logic              o_alloc,
  output logic [CKW-1:0]    o_chk_id,
  output logic              o_chk,
  input  logic              i_release,
  input  logic              i_restore,
  input  logic [CKW-1:0]    i_restore_id
);

  localparam int NREGS = 1 << AWIDTH;
  localparam logic [CKW:0] CK_FULL = (CKW+1)'(CKNUM);

  logic [PWIDTH-1:0] map_q  [NREGS];
  logic [PWIDTH-1:0] map_nx [NREGS];
  logic [PWIDTH-1:0] ckpt_q [CKNUM][NREGS];

  logic [CKW-1:0] head_q;
  logic [CKW-1:0] tail_q;
  logic [CKW:0]   count_q;

  logic           alloc;
  logic           ck_full;
  logic           fire;
  logic           save;
  logic           release_ok;
  logic [CKW-1:0] restore_dist;
  logic [CKW:0]   save_w;
  logic [CKW:0]   rel_w;

  // Entry 0 is hardwired to physical 0, so x0 never allocates.
  assign alloc        = i_rd_we && (i_rd != '0);
  assign ck_full      = (count_q == CK_FULL);
  assign o_ready      = (!o_valid || i_ready) && !i_restore &&
                        !(alloc && i_fl_empty) && !(i_chk_save && ck_full);
  assign fire         = i_valid && o_ready;
  assign o_fl_re      = fire && alloc;
  assign save         = fire && i_chk_save;
  assign release_ok   = i_release && (count_q != '0);
  assign restore_dist = i_restore_id - head_q;
  assign save_w       = {{CKW{1'b0}}, save};
  assign rel_w        = {{CKW{1'b0}}, release_ok};

  // The checkpoint must capture the map including this instruction's own rd update.
  always_comb begin
    map_nx = map_q;
    if (fire && alloc) begin
      map_nx[i_rd] = i_fl_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        map_q[i] <= PWIDTH'(i);
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        map_q[i] <= i_restore ? ckpt_q[i_restore_id][i] : map_nx[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CKNUM; c++) begin
        for (int i = 0; i < NREGS; i++) begin
          ckpt_q[c][i] <= '0;
        end
      end
    end else if (save) begin
      for (int i = 0; i < NREGS; i++) begin
        ckpt_q[tail_q][i] <= map_nx[i];
      end
    end
  end

  // On restore the restored slot stays live; count is its distance from head plus one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (release_ok) begin
        head_q <= head_q + CKW'(1);
      end
      if (i_restore) begin
        tail_q  <= i_restore_id + CKW'(1);
        count_q <= {1'b0, restore_dist} + (CKW+1)'(1) - rel_w;
      end else begin
        if (save) begin
          tail_q <= tail_q + CKW'(1);
        end
        count_q <= count_q + save_w - rel_w;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_prs1   <= '0;
      o_prs2   <= '0;
      o_prd    <= '0;
      o_pold   <= '0;
      o_alloc  <= 1'b0;
      o_chk    <= 1'b0;
      o_chk_id <= '0;
    end else if (i_restore) begin
      o_valid <= 1'b0;
    end else if (fire) begin
      o_valid  <= 1'b1;
      o_prs1   <= map_q[i_rs1];
      o_prs2   <= map_q[i_rs2];
      o_prd    <= alloc ? i_fl_data : '0;
      o_pold   <= alloc ? map_q[i_rd] : '0;
      o_alloc  <= alloc;
      o_chk    <= i_chk_save;
      o_chk_id <= i_chk_save ? tail_q : '0;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
